// File: rtl/nmr_bstrm_pkg.sv
`timescale 1ns/1ps
// Shared types and instruction-word layout for the NMR bitstream sequencer.
package nmr_bstrm_pkg;

    // Instruction opcodes
    typedef enum logic [1:0] {
        OpPulse     = 2'd0,
        OpLoopStart = 2'd1,
        OpLoopEnd   = 2'd2,
        OpEnd       = 2'd3
    } op_t;

    // Word layout is {op[1:0], mux[3:0], pol, len[DATA_WIDTH-1:0]}.
    // LEN_LSB is absolute; the others are offsets above the len field.
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned POL_BIT = 0;
    localparam int unsigned MUX_LSB = 1;
    localparam int unsigned OP_LSB  = 5;
    localparam int unsigned CTRL_W  = 7;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StAck,
        StDrain
    } state_t;

endpackage

// File: rtl/nmr_bstrm_loop_ctr.sv
`timescale 1ns/1ps
// Single-level hardware loop state: remaining count, body address, active flag.
module nmr_bstrm_loop_ctr
    import nmr_bstrm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_dec,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_cnt,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_last,
    output logic                  o_active,
    output logic [ADDR_WIDTH-1:0] o_loop_addr
);

    logic [DATA_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_active;

    // Loop registers; a repeat count of 0 behaves as 1
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= (i_cnt == '0) ? DATA_WIDTH'(1) : i_cnt;
            r_addr   <= i_addr;
            r_active <= 1'b1;
        end else if (i_dec) begin
            r_cnt    <= r_cnt - DATA_WIDTH'(1);
        end
    end

    assign o_last      = (r_cnt <= DATA_WIDTH'(1));
    assign o_active    = r_active;
    assign o_loop_addr = r_addr;

endmodule

// File: rtl/nmr_bstrm_seq_ctrl.sv
`timescale 1ns/1ps
// Instruction sequencer driving the NMR bitstream datapath START handshake.
module nmr_bstrm_seq_ctrl
    import nmr_bstrm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MIN_LEN    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_go,
    input  logic                         i_abort,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    output logic                         o_mem_rd,
    input  logic [DATA_WIDTH+CTRL_W-1:0] i_mem_q,
    input  logic                         i_dpath_rdy,
    input  logic                         i_dpath_done,
    output logic                         o_bs_start,
    output logic [DATA_WIDTH-1:0]        o_bs_data,
    output logic                         o_bs_pol,
    output logic [3:0]                   o_bs_mux,
    output logic                         o_busy,
    output logic                         o_seq_done,
    output logic                         o_err
);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic                  r_bs_start, w_bs_start_nxt;
    logic [DATA_WIDTH-1:0] r_bs_data, w_bs_data_nxt;
    logic                  r_bs_pol, w_bs_pol_nxt;
    logic [3:0]            r_bs_mux, w_bs_mux_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_seq_done, w_seq_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_end_ok, w_end_ok_nxt;      // END reached, so DRAIN pulses SEQ_DONE
    logic                  r_abort_pend, w_abort_pend_nxt; // ABORT seen in ACK before RDY fell

    logic                  w_lp_load, w_lp_dec, w_lp_clr;
    logic                  w_lp_last, w_lp_active;
    logic [ADDR_WIDTH-1:0] w_lp_addr;

    op_t                   w_op;
    logic [DATA_WIDTH-1:0] w_len;
    logic                  w_pol;
    logic [3:0]            w_mux;
    logic                  w_pc_last;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_unused;

    assign w_op      = op_t'(i_mem_q[DATA_WIDTH+OP_LSB +: 2]);
    assign w_len     = i_mem_q[LEN_LSB +: DATA_WIDTH];
    assign w_pol     = i_mem_q[DATA_WIDTH+POL_BIT];
    assign w_mux     = i_mem_q[DATA_WIDTH+MUX_LSB +: 4];
    assign w_pc_last = &r_pc;
    assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
    // Pulse completion is tracked through RDY alone
    assign w_unused  = i_dpath_done;

    nmr_bstrm_loop_ctr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_loop_ctr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_lp_load),
        .i_dec       (w_lp_dec),
        .i_clr       (w_lp_clr),
        .i_cnt       (w_len),
        .i_addr      (w_pc_inc),
        .o_last      (w_lp_last),
        .o_active    (w_lp_active),
        .o_loop_addr (w_lp_addr)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_bs_start_nxt   = 1'b0;
        w_bs_data_nxt    = r_bs_data;
        w_bs_pol_nxt     = r_bs_pol;
        w_bs_mux_nxt     = r_bs_mux;
        w_busy_nxt       = r_busy;
        w_seq_done_nxt   = 1'b0;
        w_err_nxt        = r_err;
        w_end_ok_nxt     = r_end_ok;
        w_abort_pend_nxt = r_abort_pend;
        w_lp_load        = 1'b0;
        w_lp_dec         = 1'b0;
        w_lp_clr         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_go) begin
                    w_pc_nxt         = i_base_addr;
                    w_err_nxt        = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_end_ok_nxt     = 1'b0;
                    w_abort_pend_nxt = 1'b0;
                    w_lp_clr         = 1'b1;
                    w_state_nxt      = StFetch;
                end
            end
            StFetch: begin
                w_state_nxt = i_abort ? StDrain : StDecode;
            end
            StDecode: begin
                w_state_nxt = StFetch;
                if (i_abort) begin
                    w_state_nxt = StDrain;
                end else begin
                    unique case (w_op)
                        OpPulse: begin
                            if (w_len < DATA_WIDTH'(MIN_LEN)) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = StDrain;
                            end else begin
                                w_bs_data_nxt = w_len;
                                w_bs_pol_nxt  = w_pol;
                                w_bs_mux_nxt  = w_mux;
                                w_state_nxt   = StIssue;
                            end
                        end
                        OpLoopStart: begin
                            if (w_lp_active || w_pc_last) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = StDrain;
                            end else begin
                                w_lp_load = 1'b1;
                                w_pc_nxt  = w_pc_inc;
                            end
                        end
                        OpLoopEnd: begin
                            if (!w_lp_active) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = StDrain;
                            end else if (!w_lp_last) begin
                                w_lp_dec = 1'b1;
                                w_pc_nxt = w_lp_addr;
                            end else if (w_pc_last) begin
                                w_lp_clr    = 1'b1;
                                w_err_nxt   = 1'b1;
                                w_state_nxt = StDrain;
                            end else begin
                                w_lp_clr = 1'b1;
                                w_pc_nxt = w_pc_inc;
                            end
                        end
                        OpEnd: begin
                            w_end_ok_nxt = 1'b1;
                            w_state_nxt  = StDrain;
                        end
                        default: w_state_nxt = StDrain;
                    endcase
                end
            end
            StIssue: begin
                if (i_abort) begin
                    w_state_nxt = StDrain;
                end else if (i_dpath_rdy) begin
                    w_bs_start_nxt = 1'b1;
                    w_state_nxt    = StAck;
                end
            end
            StAck: begin
                // RDY falling confirms the datapath has taken START
                if (!i_dpath_rdy) begin
                    if (i_abort || r_abort_pend) begin
                        w_state_nxt = StDrain;
                    end else if (w_pc_last) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = StDrain;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = StFetch;
                    end
                end else if (i_abort) begin
                    w_abort_pend_nxt = 1'b1;
                end
            end
            StDrain: begin
                if (i_dpath_rdy) begin
                    w_seq_done_nxt = r_end_ok;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pc         <= '0;
            r_bs_start   <= 1'b0;
            r_bs_data    <= '0;
            r_bs_pol     <= 1'b0;
            r_bs_mux     <= '0;
            r_busy       <= 1'b0;
            r_seq_done   <= 1'b0;
            r_err        <= 1'b0;
            r_end_ok     <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_bs_start   <= w_bs_start_nxt;
            r_bs_data    <= w_bs_data_nxt;
            r_bs_pol     <= w_bs_pol_nxt;
            r_bs_mux     <= w_bs_mux_nxt;
            r_busy       <= w_busy_nxt;
            r_seq_done   <= w_seq_done_nxt;
            r_err        <= w_err_nxt;
            r_end_ok     <= w_end_ok_nxt;
            r_abort_pend <= w_abort_pend_nxt;
        end
    end

    assign o_mem_addr = r_pc;
    assign o_mem_rd   = (r_state == StFetch);
    assign o_bs_start = r_bs_start;
    assign o_bs_data  = r_bs_data;
    assign o_bs_pol   = r_bs_pol;
    assign o_bs_mux   = r_bs_mux;
    assign o_busy     = r_busy;
    assign o_seq_done = r_seq_done;
    assign o_err      = r_err;

endmodule
